// File: rtl/fib_seq.sv
// Iterative Fibonacci engine: a start/done handshake FSM that reuses one adder and reports exact overflow.
// Optional build macro FIB_SAT_EN saturates fib_n to all-ones when F(n) overflows DATA_W bits.
module fib_seq #(
  parameter int N_W    = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] fib_n,
  output logic              overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] b_nxt;
  logic [N_W-1:0]    cnt_r;
  logic [N_W-1:0]    cnt_nxt;
  logic              ovf_a_r;
  logic              ovf_a_nxt;
  logic              ovf_b_r;
  logic              ovf_b_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [DATA_W-1:0] fib_nxt;
  logic              overflow_nxt;
  logic [DATA_W:0]   sum;

`ifdef FIB_SAT_EN
  function automatic logic [DATA_W-1:0] sat_result(input logic [DATA_W-1:0] val, input logic ovf);
    if (ovf) begin
      return {DATA_W{1'b1}};
    end else begin
      return val;
    end
  endfunction
`endif

  // Shared adder; the extra MSB is the carry that feeds overflow tracking.
  always_comb begin
    sum = {1'b0, a_r} + {1'b0, b_r};
  end

  // Next-state and datapath control for the IDLE/CALC sequencer.
  always_comb begin
    state_nxt    = state_r;
    a_nxt        = a_r;
    b_nxt        = b_r;
    cnt_nxt      = cnt_r;
    ovf_a_nxt    = ovf_a_r;
    ovf_b_nxt    = ovf_b_r;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    fib_nxt      = fib_n;
    overflow_nxt = overflow;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_nxt     = {DATA_W{1'b0}};
          b_nxt     = {{(DATA_W-1){1'b0}}, 1'b1};
          cnt_nxt   = n;
          ovf_a_nxt = 1'b0;
          ovf_b_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt_r != {N_W{1'b0}}) begin
          a_nxt     = b_r;
          b_nxt     = sum[DATA_W-1:0];
          // b tracks F(k+1), so its flag can be set while F(k) in a still fits.
          ovf_a_nxt = ovf_b_r;
          ovf_b_nxt = ovf_a_r | ovf_b_r | sum[DATA_W];
          cnt_nxt   = cnt_r - {{(N_W-1){1'b0}}, 1'b1};
        end else begin
`ifdef FIB_SAT_EN
          fib_nxt      = sat_result(a_r, ovf_a_r);
`else
          fib_nxt      = a_r;
`endif
          overflow_nxt = ovf_a_r;
          done_nxt     = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= {DATA_W{1'b0}};
      b_r      <= {DATA_W{1'b0}};
      cnt_r    <= {N_W{1'b0}};
      ovf_a_r  <= 1'b0;
      ovf_b_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fib_n    <= {DATA_W{1'b0}};
      overflow <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      a_r      <= a_nxt;
      b_r      <= b_nxt;
      cnt_r    <= cnt_nxt;
      ovf_a_r  <= ovf_a_nxt;
      ovf_b_r  <= ovf_b_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      fib_n    <= fib_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

// File: doc/fib_seq.md
Name: fib_seq

Overview:
Iterative, parameterised Fibonacci engine that computes F(n) with a start/done handshake. It supersedes the combinational 4-bit-index lookup: the index and result widths are generic, the result is produced by a small FSM that reuses one adder, and overflow is reported. It sits behind any controller that issues a request and then waits for completion.

Parameters:
N_W, 6, width of index n (n in 0 .. 2^N_W-1)
DATA_W, 32, width of result fib_n and internal accumulators

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
n  input  N_W  index; captured on the accepted start edge
busy  output  1  high while a computation is in progress
done  output  1  one-cycle completion pulse
fib_n  output  DATA_W  result of the last completed computation; held until the next completion
overflow  output  1  F(n) did not fit in DATA_W bits; valid with done, held with fib_n

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, fib_n=0, overflow=0; internal a, b, cnt and flags are cleared. Reset mid-computation aborts it with no done pulse.
- States: IDLE, CALC.
- IDLE, start=1: load a=0, b=1, cnt=n, ovf_a=0, ovf_b=0 -> CALC; busy=1 from the next cycle.
- IDLE, start=0: stay in IDLE.
- CALC, cnt!=0:
  - a<=b
  - b<=a+b, truncated to DATA_W; carry = carry out of that add
  - ovf_a<=ovf_b
  - ovf_b<=ovf_a|ovf_b|carry
  - cnt<=cnt-1
- CALC, cnt==0:
  - fib_n<=result(a, ovf_a); overflow<=ovf_a
  - done<=1 for exactly one cycle; busy<=0 -> IDLE
- Latency: for a start sampled at edge E, done is high after edge E+n+1 (n=0 gives 1 edge; n=10 gives 11 edges). Throughput: one request per n+2 cycles.
- start while busy: ignored, not queued. Changes to n during CALC: ignored.
- start high in the cycle where done=1: accepted, because the FSM is already in IDLE. The next computation begins and fib_n/overflow hold the old result until their own done.
- Overflow tracking is exact. ovf_b can be set by F(n+1) while ovf_a for F(n) stays clear, so overflow=1 if and only if F(n) >= 2^DATA_W.
- fib_n and overflow change only on a done edge or on reset.

Optional Feature:
Macro FIB_SAT_EN.
- Defined: result(a, ovf_a) = all-ones (2^DATA_W-1) when ovf_a=1, otherwise a. The output saturates.
- Not defined: result(a, ovf_a) = a, i.e. F(n) mod 2^DATA_W (wrap-around).
- overflow behaves identically in both builds.

Test Plan:
- Reset then idle: rst_n=0 for 2 edges, then start=0 -> busy=0, done=0, fib_n=0, overflow=0.
- Defaults, n=0, then n=1, then n=15: done after 1, 2 and 16 edges respectively; fib_n=0, 1, 610; overflow=0; busy high for exactly n+1 cycles each.
- Defaults, n=47 -> fib_n=2971215073, overflow=0. Then n=48 -> overflow=1; fib_n=512559680 without FIB_SAT_EN, 0xFFFFFFFF with it.
- DATA_W=16: n=24 -> 46368, overflow=0 (ovf_b set internally, must not leak). n=25 -> overflow=1; fib_n=9489 without FIB_SAT_EN, 65535 with it.
- Handshake: pulse start with n=10, then pulse start with n=3 and change n while busy -> single done after 11 edges, fib_n=55. Assert start (n=5) in the done cycle -> accepted; fib_n stays 55 until the second done, 6 edges later, gives 5.
- Reset mid-op: start n=20, drop rst_n at edge 5 -> no done; all outputs 0. A fresh start with n=7 then gives 13.
